// File: rtl/host_mem_pkg.sv
// Shared types and constants for the host-side line-store responder.
package host_mem_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2,
    WR_WAIT = 2'd3
  } hm_state;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps 8,6,5,4 expressed as a bit mask over lfsr[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/host_mem_lfsr.sv
// 8-bit Fibonacci LFSR supplying per-request latency jitter.
module host_mem_lfsr
  import host_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= LFSR_SEED;
    end else begin
      out <= {out[6:0], ^(out & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/host_mem_responder.sv
// Line-addressed memory responder: clears itself after reset, then serves whole-line
// reads/writes with fixed latency. Define HOST_MEM_JITTER_EN to add 0-3 random extra cycles.
module host_mem_responder
  import host_mem_pkg::*;
#(
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64,
  parameter int DEPTH_LINES   = 256,
  parameter int RD_LATENCY    = 4,
  parameter int WR_LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_re,
  input  logic                     host_we,
  input  logic [ADDR_BITCOUNT-1:0] host_addr,
  input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_in,
  output logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_out,
  output logic                     host_rd_ready,
  output logic                     host_wr_ready,
  output logic                     host_init,
  output logic                     busy
);

  localparam int OFF     = $clog2(CL_SIZE_WIDTH / 8);
  localparam int LB      = $clog2(DEPTH_LINES);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 4);

  logic [CL_SIZE_WIDTH-1:0] mem_q [DEPTH_LINES];
  hm_state                  state_q;
  logic [LB-1:0]            clr_idx_q;
  logic [LB-1:0]            idx_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CL_SIZE_WIDTH-1:0] wdata_q;
  logic [CL_SIZE_WIDTH-1:0] rdata_q;
  logic                     rd_rdy_q;
  logic                     wr_rdy_q;
  logic                     init_q;

  logic [LB-1:0]            addr_idx;
  logic [1:0]               jit;
  logic [CNT_W-1:0]         rd_load_d;
  logic [CNT_W-1:0]         wr_load_d;
  logic                     unused_addr;

  assign addr_idx    = host_addr[OFF+LB-1:OFF];
  assign unused_addr = ^{host_addr[ADDR_BITCOUNT-1:OFF+LB], host_addr[OFF-1:0]};

`ifdef HOST_MEM_JITTER_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;

  host_mem_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );

  assign jit         = lfsr[1:0];
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign jit = 2'd0;
`endif

  assign rd_load_d = CNT_W'(RD_LATENCY - 1) + CNT_W'(jit);
  assign wr_load_d = CNT_W'(WR_LATENCY - 1) + CNT_W'(jit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rd_rdy_q  <= 1'b0;
      wr_rdy_q  <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      rd_rdy_q <= 1'b0;
      wr_rdy_q <= 1'b0;
      case (state_q)
        INIT: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == LB'(DEPTH_LINES - 1)) begin
            state_q <= IDLE;
            init_q  <= 1'b1;
          end
        end
        IDLE: begin
          // Write takes priority; a still-held read is picked up on a later IDLE cycle.
          if (host_we) begin
            cnt_q   <= wr_load_d;
            state_q <= WR_WAIT;
          end else if (host_re) begin
            cnt_q   <= rd_load_d;
            state_q <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt_q == '0) begin
            wr_rdy_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            rd_rdy_q <= 1'b1;
            rdata_q  <= mem_q[idx_q];
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Array and captured request fields carry no reset; INIT overwrites every line.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && (host_we || host_re)) begin
      idx_q <= addr_idx;
    end
    if (state_q == IDLE && host_we) begin
      wdata_q <= host_data_bus_write_in;
    end
    if (state_q == INIT) begin
      mem_q[clr_idx_q] <= '0;
    end else if (state_q == WR_WAIT && cnt_q == '0) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign host_data_bus_read_out = rdata_q;
  assign host_rd_ready          = rd_rdy_q;
  assign host_wr_ready          = wr_rdy_q;
  assign host_init              = init_q;
  assign busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_host_mem_responder.sv
// Directed bench for host_mem_responder with a transaction-level expectation model.
module tb_host_mem_responder;

  localparam int CL   = 512;
  localparam int AW   = 64;
  localparam int DEP  = 256;
  localparam int RLAT = 4;
  localparam int WLAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_re, host_we;
  logic [AW-1:0] host_addr;
  logic [CL-1:0] wdata;
  logic [CL-1:0] rdata;
  logic          rd_rdy, wr_rdy, h_init, busy;

  host_mem_responder #(
    .CL_SIZE_WIDTH (CL),
    .ADDR_BITCOUNT (AW),
    .DEPTH_LINES   (DEP),
    .RD_LATENCY    (RLAT),
    .WR_LATENCY    (WLAT)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .host_re                (host_re),
    .host_we                (host_we),
    .host_addr              (host_addr),
    .host_data_bus_write_in (wdata),
    .host_data_bus_read_out (rdata),
    .host_rd_ready          (rd_rdy),
    .host_wr_ready          (wr_rdy),
    .host_init              (h_init),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            acc;
    int            strobe;
    bit            is_rd;
    logic [CL-1:0] data;
  } xfer_t;

  int            cyc = 0;
  int            rel = 0;
  int            tot = 0;
  int            bad = 0;
  xfer_t         q[$];
  logic [CL-1:0] mmem [DEP];
  logic [CL-1:0] exp_rdata;
  logic [7:0]    blfsr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) blfsr <= 8'hA5;
    else        blfsr <= {blfsr[6:0], ^(blfsr & 8'hB8)};
  end

  function automatic logic [7:0] adv(logic [7:0] v, int n);
    for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
    return v;
  endfunction

  function automatic int line_of(logic [AW-1:0] a);
    return int'((a >> 6) % DEP);
  endfunction

  task automatic chk(string name, logic [CL-1:0] act, logic [CL-1:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Schedule a request in the model; returns the predicted strobe cycle.
  function automatic int plan(bit is_rd, logic [AW-1:0] a, logic [CL-1:0] d);
    xfer_t x;
    int    lat;
    logic [7:0] l;
    x.acc = cyc + 1;
    if (q.size() > 0 && q[$].strobe + 1 > x.acc) x.acc = q[$].strobe + 1;
    l   = adv(blfsr, x.acc - 1 - cyc);
    lat = is_rd ? RLAT : WLAT;
`ifdef HOST_MEM_JITTER_EN
    lat += int'(l[1:0]);
`endif
    x.strobe = x.acc + lat;
    x.is_rd  = is_rd;
    if (is_rd) begin
      x.data = mmem[line_of(a)];
    end else begin
      mmem[line_of(a)] = d;
      x.data = d;
    end
    q.push_back(x);
    return x.strobe;
  endfunction

  always @(negedge clk) begin
    bit init_ok, e_rd, e_wr, e_busy;
    while (q.size() > 0 && q[0].strobe < cyc) void'(q.pop_front());
    init_ok = rst_n && (cyc >= rel + DEP);
    e_rd = 1'b0; e_wr = 1'b0; e_busy = !init_ok;
    foreach (q[i]) begin
      if (q[i].strobe == cyc) begin
        if (q[i].is_rd) begin
          e_rd = 1'b1;
          exp_rdata = q[i].data;
        end else begin
          e_wr = 1'b1;
        end
      end
      if (q[i].acc <= cyc && cyc < q[i].strobe) e_busy = 1'b1;
    end
    chk("host_init", CL'(h_init), CL'(init_ok));
    chk("busy", CL'(busy), CL'(e_busy));
    chk("rd_ready", CL'(rd_rdy), CL'(e_rd));
    chk("wr_ready", CL'(wr_rdy), CL'(e_wr));
    chk("rdata", rdata, exp_rdata);
  end

  task automatic wait_strobe(bit is_rd, output int at);
    at = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (is_rd ? rd_rdy : wr_rdy) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      bad++;
      $display("FAIL %s_timeout cyc=%0d", is_rd ? "rd" : "wr", cyc);
    end
  endtask

  task automatic xfer(bit is_rd, logic [AW-1:0] a, logic [CL-1:0] d, output int acc, output int at);
    int p;
    p = plan(is_rd, a, d);
    acc = q[$].acc;
    host_addr = a;
    wdata = d;
    if (is_rd) host_re = 1'b1; else host_we = 1'b1;
    wait_strobe(is_rd, at);
    host_re = 1'b0;
    host_we = 1'b0;
    if (at >= 0) chk(is_rd ? "rd_at_plan" : "wr_at_plan", CL'(at), CL'(p));
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!h_init && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_rdata = '0;
    foreach (mmem[i]) mmem[i] = '0;
  endtask

  initial begin
    int acc, at, at2, n, p;
    logic [CL-1:0] pat, pat2;
    pat  = {16{32'hDEADBEEF}};
    pat2 = {8{64'h0123_4567_89AB_CDEF}};
    rst_n = 1'b0; host_re = 1'b0; host_we = 1'b0; host_addr = '0; wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rdata", rdata, '0);
    chk("reset_busy", CL'(busy), CL'(1));
    rst_n = 1'b1;
    rel = cyc;
    wait_init(n);
    chk("init_cycles", CL'(n), CL'(256));

    xfer(1'b0, 64'h40, pat, acc, at);
`ifndef HOST_MEM_JITTER_EN
    chk("wr_latency", CL'(at - acc), CL'(4));
`endif
    xfer(1'b1, 64'h40, '0, acc, at);
`ifndef HOST_MEM_JITTER_EN
    chk("rd_latency", CL'(at - acc), CL'(4));
`endif
    chk("rd_line1", rdata, {16{32'hDEADBEEF}});

    xfer(1'b0, 64'h0, 512'h1, acc, at);
    xfer(1'b1, 64'h4000, '0, acc, at);
    chk("rd_wrap", rdata, 512'h1);

    // Simultaneous write and read to the same line
    p = plan(1'b0, 64'h80, pat2);
    p = plan(1'b1, 64'h80, '0);
    host_addr = 64'h80; wdata = pat2; host_we = 1'b1; host_re = 1'b1;
    wait_strobe(1'b0, at);
    host_we = 1'b0;
    wait_strobe(1'b1, at2);
    host_re = 1'b0;
    chk("both_rd_at", CL'(at2), CL'(p));
`ifndef HOST_MEM_JITTER_EN
    chk("both_gap", CL'(at2 - at), CL'(5));
`endif
    chk("both_data", rdata, {8{64'h0123_4567_89AB_CDEF}});

    // Write request dropped one cycle after acceptance still commits
    p = plan(1'b0, 64'hC0, ~pat);
    host_addr = 64'hC0; wdata = ~pat; host_we = 1'b1;
    @(negedge clk); #1;
    host_we = 1'b0; wdata = '0;
    wait_strobe(1'b0, at);
    chk("drop_wr_at", CL'(at), CL'(p));
    xfer(1'b1, 64'hC0, '0, acc, at);
    chk("drop_wr_data", rdata, ~{16{32'hDEADBEEF}});

    // Reset while a read is waiting
    p = plan(1'b1, 64'h40, '0);
    host_addr = 64'h40; host_re = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0; host_re = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_init", CL'(h_init), CL'(0));
    rst_n = 1'b1;
    rel = cyc;
    wait_init(n);
    chk("reinit_cycles", CL'(n), CL'(256));
    xfer(1'b1, 64'h40, '0, acc, at);
    chk("reinit_line1", rdata, '0);
    xfer(1'b1, 64'hC0, '0, acc, at);
    chk("reinit_line3", rdata, '0);

    // Stream of reads with varying addresses; latency bounded in all builds
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) xfer(1'b0, 64'(i * 64), {16{32'(i)}}, acc, at);
      xfer(1'b1, 64'((i % 12) * 64), '0, acc, at);
      tot++;
      if (at - acc < RLAT || at - acc > RLAT + 3) begin
        bad++;
        $display("FAIL rd_lat_range got=%0d want=%0d..%0d", at - acc, RLAT, RLAT + 3);
      end
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
